io_sevenseg_driver: RTL and testbench
=====================================

IO_SEVENSEG_DRIVER -- requirements
Module: io_sevenseg_driver

Interface
REQ-001 The block SHALL have one parameter: REFRESH_DIV, default 50000, clock cycles each digit is displayed (legal range 1..2^20).
REQ-002 The block SHALL have one clock, clk, and a synchronous active-high reset, reset.
REQ-003 clk  in  1  rising-edge system clock, shared with the IO memory block.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 value  in  16  output-port word driven by the IO memory block's toOutput.
REQ-006 load  in  1  capture strobe; value is latched on a rising clk edge while load=1.
REQ-007 blank_lz  in  1  1 = suppress leading-zero digits 3..1.
REQ-008 dp_en  in  4  per-digit decimal-point enable, bit i = digit i.
REQ-009 an  out  4  active-low digit anodes; an[i] drives digit i (digit 0 = least significant nibble).
REQ-010 seg  out  7  active-low segments {g,f,e,d,c,b,a}.
REQ-011 dp  out  1  active-low decimal point.
REQ-012 shown  out  16  currently latched display word.

Function
REQ-013 Latch: on a rising edge with load=1, shown SHALL take value; with load=0, shown SHALL hold.
REQ-014 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; the wrap cycle is the terminal count (tc).
REQ-015 With REFRESH_DIV=1, tc SHALL be asserted every cycle.
REQ-016 Scan FSM states: D0, D1, D2, D3; on tc, D0->D1->D2->D3->D0; otherwise hold.
REQ-017 an, seg and dp SHALL be registered, computed each edge from the current FSM state and the current shown; output latency is 1 cycle after a state or shown change.
REQ-018 In state Di, unblanked: an = all 1s except an[i]=0; seg = decode of shown[4i+3:4i]; dp = ~dp_en[i].
REQ-019 Decode (hex nibble -> seg): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-020 Digit i (i=1..3) SHALL be blanked when blank_lz=1 and shown[15:4i]==0; digit 0 SHALL never be blanked.
REQ-021 Blanked digit slot: an=4'b1111, seg=7'h7F, dp=1 (dp_en ignored); the FSM still dwells REFRESH_DIV cycles there.
REQ-022 At most one an bit SHALL be 0 in any cycle.
REQ-023 load coinciding with tc: both SHALL take effect on the same edge; the next digit is shown with the new value.
REQ-024 load held high for several cycles SHALL re-capture value every cycle; the display follows with 1-cycle latency.
REQ-025 blank_lz and dp_en SHALL be sampled live (not latched by load).

Reset
REQ-026 On a reset edge: shown=16'h0000, counter=0, FSM=D0, an=4'b1111, seg=7'h7F, dp=1.
REQ-027 reset SHALL take priority over load and tc on the same edge.
REQ-028 On the first edge after reset deasserts: an=4'b1110, seg=7'h40 (digit 0 shows "0").
REQ-029 reset asserted mid-scan SHALL abort the current dwell; no partial count SHALL survive.

Verification (REFRESH_DIV=4)
REQ-030 Reset, then load value=16'h1234 for one cycle -> shown=16'h1234 next edge; digit slots in order show an=1110/seg=19, 1101/30, 1011/24, 0111/79, each lasting exactly 4 cycles.
REQ-031 blank_lz=1, load 16'h0005 -> digit 0 an=1110 seg=12; slots D1..D3 show an=1111 seg=7F; cycle through D0 repeats every 16 cycles.
REQ-032 blank_lz=1, load 16'h0000 -> only digit 0 lit, seg=40; load 16'hF00A -> all four digits lit (0E,40,40,08 for D3..D0), middle zeros not blanked.
REQ-033 dp_en=4'b0100, value 16'hABCD -> dp=0 only in D2 slot (seg=03); dp=1 elsewhere.
REQ-034 load asserted on the tc edge from D1 with 16'h00FF -> D2 slot immediately shows seg=40 (blank_lz=0); shown=16'h00FF.
REQ-035 Assert reset during D2 dwell with load=1 on the same edge -> shown=0, an=1111, seg=7F; scan restarts at D0 with a full 4-cycle dwell.

Source files
------------

// File: rtl/io_sevenseg_driver.sv
// ---------------------------------------------------------------------------
// io_sevenseg_driver
//
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A 16-bit word is captured from the IO memory block and shown as four hex
// digits, one digit lit at a time, each for REFRESH_DIV clock cycles.
//
// Parameters
//   REFRESH_DIV  clock cycles each digit is displayed (1 .. 2^20)
//
// Ports
//   clk       in   1   rising-edge system clock
//   reset     in   1   synchronous active-high reset
//   value     in  16   word to display (IO memory toOutput)
//   load      in   1   capture strobe for value
//   blank_lz  in   1   1 = suppress leading-zero digits 3..1
//   dp_en     in   4   per-digit decimal-point enable
//   an        out  4   active-low digit anodes, an[i] = digit i
//   seg       out  7   active-low segments {g,f,e,d,c,b,a}
//   dp        out  1   active-low decimal point
//   shown     out 16   currently latched display word
// ---------------------------------------------------------------------------
module io_sevenseg_driver #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [3:0]  dp_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [15:0] shown
);

    // A one-cycle dwell still needs a 1-bit counter that simply stays at 0.
    localparam int unsigned           CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2,
        D3 = 2'd3
    } scan_state_t;

    scan_state_t      state;
    scan_state_t      next_state;
    logic [CNT_W-1:0] cnt;
    logic             tc;

    logic [3:0]       nibble;
    logic             digit_blank;
    logic [3:0]       an_next;
    logic [6:0]       seg_next;
    logic             dp_next;

    // Hex nibble to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0:    decode = 7'h40;
            4'h1:    decode = 7'h79;
            4'h2:    decode = 7'h24;
            4'h3:    decode = 7'h30;
            4'h4:    decode = 7'h19;
            4'h5:    decode = 7'h12;
            4'h6:    decode = 7'h02;
            4'h7:    decode = 7'h78;
            4'h8:    decode = 7'h00;
            4'h9:    decode = 7'h10;
            4'hA:    decode = 7'h08;
            4'hB:    decode = 7'h03;
            4'hC:    decode = 7'h46;
            4'hD:    decode = 7'h21;
            4'hE:    decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    // Display word latch.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            shown <= 16'h0000;
        end else if (load) begin
            shown <= value;
        end
    end

    // Refresh counter; tc marks the wrap cycle that advances the scan.
    assign tc = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset || tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Scan FSM: state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= D0;
        end else begin
            state <= next_state;
        end
    end

    // Scan FSM: next-state logic.
    always_comb begin
        next_state = state;
        if (tc) begin
            case (state)
                D0:      next_state = D1;
                D1:      next_state = D2;
                D2:      next_state = D3;
                default: next_state = D0;
            endcase
        end
    end

    // Scan FSM: output logic. A digit is a leading zero when it and every
    // digit above it are zero, so a zero between non-zero digits stays lit.
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nibble      = shown[3:0];
        digit_blank = 1'b0;
        an_next     = 4'b1110;
        dp_next     = ~dp_en[0];
        case (state)
            D1: begin
                nibble      = shown[7:4];
                digit_blank = blank_lz && (shown[15:4] == 12'h000);
                an_next     = 4'b1101;
                dp_next     = ~dp_en[1];
            end
            D2: begin
                nibble      = shown[11:8];
                digit_blank = blank_lz && (shown[15:8] == 8'h00);
                an_next     = 4'b1011;
                dp_next     = ~dp_en[2];
            end
            D3: begin
                nibble      = shown[15:12];
                digit_blank = blank_lz && (shown[15:12] == 4'h0);
                an_next     = 4'b0111;
                dp_next     = ~dp_en[3];
            end
            default: ;
        endcase
        seg_next = decode(nibble);
        if (digit_blank) begin
            an_next  = 4'b1111;
            seg_next = 7'h7F;
            dp_next  = 1'b1;
        end
    end

    // Registered pad outputs: glitch-free, one cycle behind state and shown.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_io_sevenseg_driver.sv
module tb_io_sevenseg_driver;

    localparam int DIV = 4;

    localparam logic [6:0] DEC [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic [3:0]  dp_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] shown;

    int checks   = 0;
    int failures = 0;

    // Reference model: the displayed word and the number of clock edges since
    // reset released. The digit being scanned is (tick / DIV) mod 4.
    logic [15:0] m_shown;
    int          m_tick;

    always #5 clk = ~clk;

    io_sevenseg_driver #(.REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .blank_lz (blank_lz),
        .dp_en    (dp_en),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .shown    (shown)
    );

    // One clock edge: predict outputs from the model's pre-edge view, advance
    // the model, then compare 1 time unit after the edge.
    task automatic step();
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [15:0] upper;
        int          dig;
        @(posedge clk);
        if (reset) begin
            e_an  = 4'b1111;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            dig   = (m_tick / DIV) % 4;
            upper = m_shown >> (4 * dig);
            if (dig != 0 && blank_lz && upper == 16'h0000) begin
                e_an  = 4'b1111;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end else begin
                e_an  = ~(4'b0001 << dig);
                e_seg = DEC[upper[3:0]];
                e_dp  = ~dp_en[dig];
            end
        end
        m_shown = reset ? 16'h0000 : (load ? value : m_shown);
        m_tick  = reset ? 0 : m_tick + 1;
        #1;
        checks += 5;
        if (an !== e_an) begin
            failures++;
            $display("FAIL model_an t=%0t: an=%b required=%b", $time, an, e_an);
        end
        if (seg !== e_seg) begin
            failures++;
            $display("FAIL model_seg t=%0t: seg=%h required=%h", $time, seg, e_seg);
        end
        if (dp !== e_dp) begin
            failures++;
            $display("FAIL model_dp t=%0t: dp=%b required=%b", $time, dp, e_dp);
        end
        if (shown !== m_shown) begin
            failures++;
            $display("FAIL model_shown t=%0t: shown=%h required=%h", $time, shown, m_shown);
        end
        if ($countones(~an) > 1) begin
            failures++;
            $display("FAIL one_anode t=%0t: an=%b required at most one low bit", $time, an);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        load     = 1'b1;
        value    = 16'($urandom);
        blank_lz = 1'b0;
        dp_en    = 4'b0000;
        repeat (3) step();
        checks++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || shown !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state: an=%b seg=%h dp=%b shown=%h required 1111/7f/1/0000",
                     an, seg, dp, shown);
        end
        reset = 1'b0;
        load  = 1'b0;
        step();
        checks++;
        if (an !== 4'b1110 || seg !== 7'h40) begin
            failures++;
            $display("FAIL first_after_reset: an=%b seg=%h required 1110/40", an, seg);
        end
    endtask

    task automatic test_scan_1234();
        logic [3:0] s_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] s_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        do_reset();
        load  = 1'b1;
        value = 16'h1234;
        step();
        load = 1'b0;
        checks++;
        if (shown !== 16'h1234) begin
            failures++;
            $display("FAIL latch_1234: shown=%h required=1234", shown);
        end
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if (an !== s_an[(k / 4) % 4] || seg !== s_seg[(k / 4) % 4]) begin
                failures++;
                $display("FAIL scan_1234 k=%0d: an=%b seg=%h required %b/%h",
                         k, an, seg, s_an[(k / 4) % 4], s_seg[(k / 4) % 4]);
            end
        end
    endtask

    task automatic test_blank_lz();
        logic [6:0] f00a [4] = '{7'h08, 7'h40, 7'h40, 7'h0E};
        blank_lz = 1'b1;
        do_reset();
        load  = 1'b1;
        value = 16'h0005;
        step();
        load = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            checks++;
            if ((k / 4) % 4 == 0) begin
                if (an !== 4'b1110 || seg !== 7'h12) begin
                    failures++;
                    $display("FAIL blank_0005_d0 k=%0d: an=%b seg=%h required 1110/12", k, an, seg);
                end
            end else if (an !== 4'b1111 || seg !== 7'h7F) begin
                failures++;
                $display("FAIL blank_0005_dx k=%0d: an=%b seg=%h required 1111/7f", k, an, seg);
            end
        end
        do_reset();
        load  = 1'b1;
        value = 16'h0000;
        step();
        load = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if (((k / 4) % 4 == 0) ? (an !== 4'b1110 || seg !== 7'h40) : (an !== 4'b1111)) begin
                failures++;
                $display("FAIL blank_0000 k=%0d: an=%b seg=%h", k, an, seg);
            end
        end
        do_reset();
        load  = 1'b1;
        value = 16'hF00A;
        step();
        load = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if (an !== ~(4'b0001 << ((k / 4) % 4)) || seg !== f00a[(k / 4) % 4]) begin
                failures++;
                $display("FAIL blank_f00a k=%0d: an=%b seg=%h required seg=%h",
                         k, an, seg, f00a[(k / 4) % 4]);
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_dp();
        dp_en = 4'b0100;
        do_reset();
        load  = 1'b1;
        value = 16'hABCD;
        step();
        load = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if (dp !== ((k / 4) % 4 != 2)) begin
                failures++;
                $display("FAIL dp_abcd k=%0d: dp=%b required=%b", k, dp, ((k / 4) % 4 != 2));
            end
            if ((k / 4) % 4 == 2) begin
                checks++;
                if (seg !== 7'h03) begin
                    failures++;
                    $display("FAIL dp_abcd_seg k=%0d: seg=%h required=03", k, seg);
                end
            end
        end
        dp_en = 4'b0000;
    endtask

    task automatic test_load_on_tc();
        blank_lz = 1'b0;
        do_reset();
        load  = 1'b1;
        value = 16'h1111;
        step();
        load = 1'b0;
        while (m_tick != 7) step();
        load  = 1'b1;
        value = 16'h00FF;
        step();
        load = 1'b0;
        checks++;
        if (shown !== 16'h00FF) begin
            failures++;
            $display("FAIL load_on_tc_shown: shown=%h required=00ff", shown);
        end
        step();
        checks++;
        if (an !== 4'b1011 || seg !== 7'h40) begin
            failures++;
            $display("FAIL load_on_tc_d2: an=%b seg=%h required 1011/40", an, seg);
        end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        load  = 1'b1;
        value = 16'h5678;
        step();
        load = 1'b0;
        while (m_tick != 9) step();
        reset = 1'b1;
        load  = 1'b1;
        value = 16'hBEEF;
        step();
        reset = 1'b0;
        load  = 1'b0;
        checks++;
        if (shown !== 16'h0000 || an !== 4'b1111 || seg !== 7'h7F) begin
            failures++;
            $display("FAIL reset_mid: shown=%h an=%b seg=%h required 0000/1111/7f", shown, an, seg);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (an !== 4'b1110) begin
                failures++;
                $display("FAIL reset_mid_dwell k=%0d: an=%b required=1110", k, an);
            end
        end
        step();
        checks++;
        if (an !== 4'b1101) begin
            failures++;
            $display("FAIL reset_mid_advance: an=%b required=1101", an);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        load = 1'b1;
        for (int k = 0; k < 6; k++) begin
            v     = 16'($urandom);
            value = v;
            step();
            checks++;
            if (shown !== v) begin
                failures++;
                $display("FAIL back_to_back k=%0d: shown=%h required=%h", k, shown, v);
            end
        end
        load = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_random();
        logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
        for (int k = 0; k < 600; k++) begin
            reset    = ($urandom_range(99) < 2);
            load     = ($urandom_range(99) < 15);
            value    = 16'($urandom) & masks[$urandom_range(4)];
            blank_lz = ($urandom_range(99) < 40);
            dp_en    = 4'($urandom);
            step();
        end
        reset = 1'b0;
        load  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_1234();
        test_blank_lz();
        test_dp();
        test_load_on_tc();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
